// File: rtl/life_row_gen.sv
// Game-of-Life row engine: WIDTH cells with runtime birth/survive masks, wrapped or tiled edges.
// Define LIFE_GENERATIONS_EN for multi-state ("Generations") decay; otherwise cells are binary.
module life_row_gen #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned WRAP   = 1,
  parameter int unsigned STATES = 4,
  parameter int unsigned SPD_W  = 2,
`ifdef LIFE_GENERATIONS_EN
  localparam int unsigned NST   = STATES,
  localparam int unsigned SW    = $clog2(STATES)
`else
  localparam int unsigned NST   = 2,
  localparam int unsigned SW    = 1
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_row,
  input  logic                frame_tick,
  input  logic [SPD_W-1:0]    speed,
  input  logic                run,
  input  logic                step,
  input  logic [8:0]          birth_mask,
  input  logic [8:0]          survive_mask,
  input  logic [WIDTH-1:0]    up_row,
  input  logic [WIDTH-1:0]    dn_row,
  input  logic [2:0]          nbr_l,
  input  logic [2:0]          nbr_r,
  output logic [WIDTH-1:0]    alive,
  output logic [WIDTH*SW-1:0] state_bus,
  output logic                gen_done,
  output logic [15:0]         gen_count
);

  if (WIDTH < 3) begin : g_bad_width
    $error("life_row_gen: WIDTH must be at least 3");
  end
  if (STATES < 3 || STATES > 16) begin : g_bad_states
    $error("life_row_gen: STATES must be in 3..16");
  end

`ifdef LIFE_GENERATIONS_EN
  localparam logic [SW-1:0] FailState = SW'(2);
`else
  localparam logic [SW-1:0] FailState = '0;
`endif

  logic [WIDTH-1:0][SW-1:0] cell_q, cell_d;
  logic [WIDTH-1:0]         alive_v;
  logic [WIDTH+1:0]         up_x, mid_x, dn_x;
  logic [WIDTH-1:0][3:0]    cnt;
  logic [SPD_W-1:0]         tick_q;
  logic [15:0]              gen_q;
  logic                     upd_q, done_q;
  logic                     tick_fire, upd;
  logic                     unused_edge;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      alive_v[i] = (cell_q[i] == SW'(1));
    end
  end

  // Bit 0 of each extended vector is the column left of cell 0, bit WIDTH+1 the one right of
  // cell WIDTH-1, so cell i sees columns i, i+1, i+2.
  if (WRAP != 0) begin : g_wrap
    assign up_x  = {up_row[0],  up_row,  up_row[WIDTH-1]};
    assign mid_x = {alive_v[0], alive_v, alive_v[WIDTH-1]};
    assign dn_x  = {dn_row[0],  dn_row,  dn_row[WIDTH-1]};
  end else begin : g_tile
    assign up_x  = {nbr_r[2], up_row,  nbr_l[2]};
    assign mid_x = {nbr_r[1], alive_v, nbr_l[1]};
    assign dn_x  = {nbr_r[0], dn_row,  nbr_l[0]};
  end
  assign unused_edge = ^{nbr_l, nbr_r};

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt[i] = 4'(up_x[i]) + 4'(up_x[i+1]) + 4'(up_x[i+2])
             + 4'(mid_x[i]) + 4'(mid_x[i+2])
             + 4'(dn_x[i]) + 4'(dn_x[i+1]) + 4'(dn_x[i+2]);
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cell_d[i] = '0;
      if (cell_q[i] == '0) begin
        cell_d[i] = birth_mask[cnt[i]] ? SW'(1) : '0;
      end else if (cell_q[i] == SW'(1)) begin
        cell_d[i] = survive_mask[cnt[i]] ? SW'(1) : FailState;
`ifdef LIFE_GENERATIONS_EN
      end else if (cell_q[i] < SW'(NST - 1)) begin
        // Dying cells age regardless of neighbours; the last age returns to dead.
        cell_d[i] = cell_q[i] + SW'(1);
`endif
      end else begin
        cell_d[i] = '0;
      end
    end
  end

  assign tick_fire = run && frame_tick && (tick_q >= speed);
  assign upd       = tick_fire || (!run && step);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cell_q <= '0;
      tick_q <= '0;
      gen_q  <= '0;
      upd_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= upd_q;
      if (load) begin
        // A load drops any coincident update, including its gen_done.
        for (int i = 0; i < WIDTH; i++) begin
          cell_q[i] <= SW'(load_row[i]);
        end
        tick_q <= '0;
        gen_q  <= '0;
        upd_q  <= 1'b0;
      end else begin
        upd_q <= upd;
        if (upd) begin
          cell_q <= cell_d;
          gen_q  <= gen_q + 16'd1;
        end
        if (tick_fire) begin
          tick_q <= '0;
        end else if (run && frame_tick) begin
          tick_q <= tick_q + SPD_W'(1);
        end
      end
    end
  end

  assign alive     = alive_v;
  assign state_bus = cell_q;
  assign gen_done  = done_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_life_row_gen.sv
// Randomised bench for life_row_gen: a wrapped and a tiled instance checked against an
// array-based cell model of the Life rules, plus directed edge cases.
module tb_life_row_gen;

`ifdef LIFE_GENERATIONS_EN
  localparam int NST = 4;
  localparam int SW  = 2;
`else
  localparam int NST = 2;
  localparam int SW  = 1;
`endif
  localparam int W = 8;
  localparam logic [8:0] B3 = 9'b000001000;
  localparam logic [8:0] S23 = 9'b000001100;

  logic clk = 1'b0;
  logic rst, load, frame_tick, run, step;
  logic [W-1:0] load_row, up_row, dn_row;
  logic [1:0] speed;
  logic [8:0] birth_mask, survive_mask;
  logic [2:0] nbr_l, nbr_r;
  logic [W-1:0] alive_w, alive_n;
  logic [W*SW-1:0] sbus_w, sbus_n;
  logic done_w, done_n;
  logic [15:0] gcnt_w, gcnt_n;

  always #5 clk = ~clk;

  life_row_gen #(.WIDTH(W), .WRAP(1), .STATES(4), .SPD_W(2)) dut_w (
    .clk(clk), .rst(rst), .load(load), .load_row(load_row), .frame_tick(frame_tick),
    .speed(speed), .run(run), .step(step), .birth_mask(birth_mask),
    .survive_mask(survive_mask), .up_row(up_row), .dn_row(dn_row), .nbr_l(nbr_l),
    .nbr_r(nbr_r), .alive(alive_w), .state_bus(sbus_w), .gen_done(done_w),
    .gen_count(gcnt_w)
  );

  life_row_gen #(.WIDTH(W), .WRAP(0), .STATES(4), .SPD_W(2)) dut_n (
    .clk(clk), .rst(rst), .load(load), .load_row(load_row), .frame_tick(frame_tick),
    .speed(speed), .run(run), .step(step), .birth_mask(birth_mask),
    .survive_mask(survive_mask), .up_row(up_row), .dn_row(dn_row), .nbr_l(nbr_l),
    .nbr_r(nbr_r), .alive(alive_n), .state_bus(sbus_n), .gen_done(done_n),
    .gen_count(gcnt_n)
  );

  // Model: inst 0 wraps, inst 1 takes edges from nbr_l/nbr_r.
  int m_st[2][W];
  int m_tick, m_gen;
  bit m_pend, m_done;
  int n_chk, n_pass;
  bit do_chk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Is the neighbour at row r (0 up, 1 mid, 2 dn), column c alive, as seen by instance inst?
  function automatic int live_at(int inst, int r, int c);
    logic [2:0] edge_bits;
    if (c < 0 || c >= W) begin
      if (inst == 0) c = (c + W) % W;
      else begin
        edge_bits = (c < 0) ? nbr_l : nbr_r;
        return int'(edge_bits[2-r]);
      end
    end
    if (r == 0) return int'(up_row[c]);
    if (r == 2) return int'(dn_row[c]);
    return (m_st[inst][c] == 1) ? 1 : 0;
  endfunction

  function automatic int next_cell(int inst, int c);
    int n = 0;
    int s = m_st[inst][c];
    for (int dr = 0; dr < 3; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 1 && dc == 0)) n += live_at(inst, dr, c + dc);
    if (s == 0) return birth_mask[n] ? 1 : 0;
    if (s == 1) return survive_mask[n] ? 1 : ((NST > 2) ? 2 : 0);
    return (s == NST - 1) ? 0 : s + 1;
  endfunction

  function automatic logic [W-1:0] exp_alive(int inst);
    logic [W-1:0] v = '0;
    for (int c = 0; c < W; c++) v[c] = (m_st[inst][c] == 1);
    return v;
  endfunction

  function automatic logic [W*SW-1:0] exp_sbus(int inst);
    logic [W*SW-1:0] v = '0;
    for (int c = 0; c < W; c++) v[c*SW +: SW] = SW'(m_st[inst][c]);
    return v;
  endfunction

  task automatic check_all();
    chk("alive_w", 32'(alive_w), 32'(exp_alive(0)));
    chk("alive_n", 32'(alive_n), 32'(exp_alive(1)));
    chk("sbus_w", 32'(sbus_w), 32'(exp_sbus(0)));
    chk("sbus_n", 32'(sbus_n), 32'(exp_sbus(1)));
    chk("done_w", 32'(done_w), 32'(m_done));
    chk("done_n", 32'(done_n), 32'(m_done));
    chk("gcnt_w", 32'(gcnt_w), 32'(m_gen));
    chk("gcnt_n", 32'(gcnt_n), 32'(m_gen));
  endtask

  // One clock: predict from pre-edge inputs, clock, then compare.
  task automatic cyc();
    int nx[2][W];
    bit upd = run ? (frame_tick && m_tick >= int'(speed)) : step;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < W; c++) nx[k][c] = next_cell(k, c);
    @(posedge clk);
    #1;
    m_done = m_pend;
    if (load) begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < W; c++) m_st[k][c] = int'(load_row[c]);
      m_tick = 0;
      m_gen = 0;
      m_pend = 0;
    end else begin
      m_pend = upd;
      if (upd) begin
        m_st = nx;
        m_gen = (m_gen + 1) % 65536;
      end
      if (run && frame_tick) m_tick = (m_tick >= int'(speed)) ? 0 : m_tick + 1;
    end
    if (do_chk) check_all();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < W; c++) m_st[k][c] = 0;
    m_tick = 0; m_gen = 0; m_pend = 0; m_done = 0;
  endtask

  task automatic do_load(input logic [W-1:0] row);
    load = 1; load_row = row; cyc(); load = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; do_chk = 1;
    rst = 0; load = 0; load_row = '0; frame_tick = 0; speed = 0; run = 0; step = 0;
    birth_mask = B3; survive_mask = S23; up_row = '0; dn_row = '0; nbr_l = '0; nbr_r = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1;

    // Blinker segment in an isolated row.
    do_load(8'b00111000);
    step = 1; cyc();
    chk("blinker1", 32'(alive_w), 32'h10);
    cyc();
    chk("blinker2", 32'(alive_w), 32'h00);
    step = 0; cyc();
    chk("blinker_gen", 32'(gcnt_w), 32'd2);

    // Births from the row above, wrapped and tiled edges.
    do_load(8'b0);
    up_row = 8'b00000111; step = 1; cyc(); step = 0;
    chk("up_birth", 32'(alive_w), 32'h02);
    do_load(8'b0);
    up_row = 8'b11000000; nbr_r = 3'b100; step = 1; cyc(); step = 0;
    chk("edge_birth", 32'(alive_n), 32'h80);
    up_row = '0; nbr_r = '0;

    // Divider: every 3rd tick at speed 2, then speed lowered mid-count.
    do_load(8'b01011010);
    run = 1; speed = 2;
    for (int t = 0; t < 9; t++) begin
      frame_tick = 1; cyc(); frame_tick = 0; cyc();
    end
    chk("div_gen", 32'(gcnt_w), 32'd3);
    do_load(8'b01011010);
    speed = 3;
    frame_tick = 1; cyc(); cyc(); frame_tick = 0;
    speed = 0; frame_tick = 1; cyc(); frame_tick = 0;
    chk("speed_drop", 32'(gcnt_w), 32'd1);
    cyc();

    // Step ignored while running; load beats a same-cycle trigger.
    frame_tick = 0; step = 1; cyc(); cyc(); step = 0;
    chk("step_run", 32'(gcnt_w), 32'd1);
    run = 0; step = 1; load = 1; load_row = 8'b10100101; cyc(); load = 0; step = 0;
    chk("load_win", 32'(alive_w), 32'hA5);
    cyc();
    chk("load_nodone", 32'(done_w), 32'd0);

`ifdef LIFE_GENERATIONS_EN
    do_load(8'b00001000);
    step = 1; cyc();
    chk("age1", 32'(sbus_w[3*SW +: SW]), 32'd2);
    cyc();
    chk("age2", 32'(sbus_w[3*SW +: SW]), 32'd3);
    cyc(); step = 0;
    chk("age3", 32'(sbus_w[3*SW +: SW]), 32'd0);
`endif

    // Randomised traffic.
    for (int t = 0; t < 600; t++) begin
      load = ($urandom_range(0, 19) == 0);
      load_row = W'($urandom);
      run = ($urandom_range(0, 2) != 0);
      frame_tick = $urandom_range(0, 1) == 1;
      speed = 2'($urandom);
      step = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 0) begin
        birth_mask = B3; survive_mask = S23;
      end else begin
        birth_mask = 9'($urandom); survive_mask = 9'($urandom);
      end
      up_row = W'($urandom); dn_row = W'($urandom);
      nbr_l = 3'($urandom); nbr_r = 3'($urandom);
      cyc();
    end
    load = 0; step = 0; run = 1; frame_tick = 1; speed = 0;
    birth_mask = B3; survive_mask = S23;
    do_load(8'b11011011);
    cyc(); cyc();

    // Asynchronous reset between edges.
    #3;
    rst = 0;
    #1;
    chk("rst_alive_w", 32'(alive_w), 32'd0);
    chk("rst_sbus_n", 32'(sbus_n), 32'd0);
    chk("rst_gcnt", 32'(gcnt_w), 32'd0);
    chk("rst_done", 32'(done_w), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    run = 0; frame_tick = 0;

    // gen_count wrap.
    do_load(8'b00111000);
    do_chk = 0;
    step = 1;
    repeat (65535) cyc();
    step = 0;
    do_chk = 1;
    cyc();
    chk("gcnt_ffff", 32'(gcnt_w), 32'hFFFF);
    step = 1; cyc(); step = 0;
    chk("gcnt_wrap", 32'(gcnt_w), 32'd0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/life_row_gen.md
# life_row_gen

Parametrised Game-of-Life row engine: holds one horizontal row of `WIDTH` cells and advances all of them together, one generation at a time. It generalises the single-cell engine in three ways:
- birth/survival rule masks are supplied at runtime;
- the row edges are either wrapped or fed from neighbouring tiles;
- an optional multi-state ("Generations") decay mode is available.

Rows are stacked in the grid top level: each row's `alive` output drives the `dn_row` input of the row above and the `up_row` input of the row below. A frame-tick divider, a single-step control and a generation counter are included.

## Interface
Parameters:
- `WIDTH`, default 16: cells per row, ≥3.
- `WRAP`, default 1: 1 = horizontal toroidal wrap; 0 = edge neighbours come from `nbr_l`/`nbr_r`.
- `STATES`, default 4: states per cell in Generations mode, 3..16. Forced to 2 when the macro is off.
- `SPD_W`, default 2: width of `speed`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `load` in 1: load `load_row` this cycle.
- `load_row` in WIDTH: 1 = alive.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `speed` in SPD_W: a generation occurs every `speed+1` frame ticks.
- `run` in 1: free-running enable.
- `step` in 1: single-generation pulse; honoured only when `run`=0.
- `birth_mask` in 9: bit n = a dead cell with n live neighbours is born.
- `survive_mask` in 9: bit n = a live cell with n live neighbours survives.
- `up_row` in WIDTH: row above, alive bits.
- `dn_row` in WIDTH: row below, alive bits.
- `nbr_l` in 3: {up, mid, dn} alive bits of the column left of cell 0; used only when WRAP=0.
- `nbr_r` in 3: {up, mid, dn} alive bits of the column right of cell WIDTH-1; used only when WRAP=0.
- `alive` out WIDTH: cell i is alive (state==1).
- `state_bus` out WIDTH*SW: per-cell state, SW=$clog2(STATES), cell i at [i*SW +: SW].
- `gen_done` out 1: one-cycle pulse after each generation update.
- `gen_count` out 16: number of generations since the last load or reset.

## Operation
- Cell state encoding: 0 = dead, 1 = alive, 2..STATES-1 = dying.
- Only state 1 counts as a live neighbour.
- Neighbour count per cell: 8 neighbours, 4-bit unsigned result, range 0..8. Computed combinationally from the current states, `up_row`, `dn_row` and the edge sources.
- Edge source for cell 0's left column:
  - WRAP=1: cell WIDTH-1 and `up_row`/`dn_row` bit WIDTH-1.
  - WRAP=0: `nbr_l`.
  - The right edge of cell WIDTH-1 is handled symmetrically (bit 0, or `nbr_r`).
- Next state, with n = neighbour count:
  - state 0: becomes 1 if `birth_mask[n]`, else stays 0.
  - state 1: stays 1 if `survive_mask[n]`; otherwise becomes 2 (Generations) or 0 (binary).
  - state k ≥ 2: becomes k+1, or 0 if k = STATES-1. Neighbours are ignored and the cell cannot be born.
- Update trigger:
  - Free-running: `run`=1, `frame_tick`=1 and `tick_cnt` ≥ `speed`. `tick_cnt` then clears to 0.
  - Otherwise, while `run`=1, each `frame_tick` increments `tick_cnt`. Using ≥ keeps the divider correct when `speed` is lowered mid-count.
  - Single step: `run`=0 and `step`=1. `tick_cnt` holds.
- Load: on `load`=1, each cell takes `load_row[i]` as state 0 or 1, `tick_cnt` clears and `gen_count` clears.
- Priority and boundary cases:
  - `load` beats an update in the same cycle. The update is dropped and no `gen_done` is produced.
  - `step` while `run`=1 is ignored.
  - `gen_count` wraps from 0xFFFF to 0.
  - An all-dead row with `birth_mask[0]`=1 is born entirely. This is legal and is not special-cased.

## Timing
- Reset (`rst`=0, asynchronous) clears everything: all cell states 0, `tick_cnt` 0, `gen_count` 0, `gen_done` 0.
- Reset asserted mid-operation clears immediately. There is no pending-update carry-over.
- The update trigger is sampled at edge T. New states appear on `alive`/`state_bus` after T.
- `gen_done` is high for exactly one cycle, after edge T+1. `gen_count` increments at edge T.
- The rule masks and neighbour rows are sampled at the trigger edge only, so they may change freely between generations.
- Load takes effect at the sampling edge, with 1-cycle latency to `alive`.
- Back-to-back `step` pulses on consecutive cycles produce consecutive generations.

## Configuration
- `LIFE_GENERATIONS_EN` defined: multi-state decay as specified. SW = $clog2(STATES).
- `LIFE_GENERATIONS_EN` undefined:
  - STATES is forced to 2 and SW = 1.
  - A failed survival goes directly to 0.
  - No age logic is synthesised.
  - `state_bus` equals `alive`.

## Test plan
- B3/S23, WRAP=1, WIDTH=8; load 8'b00111000, `up_row`=`dn_row`=0; `step` → `alive`=8'b00010000. Second `step` → 8'b00000000. `gen_count`=2.
- B3/S23, WRAP=1; row=0, `up_row`=8'b00000111; `step` → `alive`=8'b00000010. With WRAP=0 and `nbr_r`=3'b100, `up_row`=8'b11000000 → bit 7 is born.
- `run`=1, `speed`=2 → a generation occurs on every 3rd `frame_tick`. Lower `speed` to 0 when `tick_cnt`=2 → the update fires on the next tick.
- Generations build, STATES=4; isolated alive cell, S23; three `step` pulses → `state_bus` cell value goes 1→2→3→0. `alive` is 0 after the first step.
- `load`=1 and the update trigger in the same cycle → `alive`=`load_row`, no `gen_done`, `gen_count`=0. `step` with `run`=1 → no change.
- Assert `rst`=0 asynchronously between edges mid-run → all outputs are 0 before the next edge. Preload `gen_count`=0xFFFF and step → 0.
